// File: rtl/debug_panel_ctrl.sv
// -----------------------------------------------------------------------------
// debug_panel_ctrl
//
// Input-side front panel for the CPU board. Raw push-buttons and the run/step
// slide switch are synchronised, debounced and edge-detected. The mode button
// cycles the LED view (ALU -> MEM -> FLAG -> PC -> OFF). The step button, or a
// free-running divider when the switch selects run mode, produces the CPU step
// strobe.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous reset, active-low
//   btn_mode    in   1  raw button: advance the LED view
//   btn_step    in   1  raw button: single step (step mode only)
//   sw_run      in   1  raw switch: 1 = free-run, 0 = single-step
//   change1     out  1  view ALU result
//   change2     out  1  view RAM data
//   change3     out  1  view ZF/OF flags
//   change4     out  1  view PC
//   view_idx    out  3  current view state code (0..4)
//   step_pulse  out  1  one-cycle CPU step strobe
//   run_mode    out  1  debounced sw_run
// -----------------------------------------------------------------------------
module debug_panel_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20,
    parameter int RUN_DIV    = 50000000,
    parameter int RUN_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_step,
    input  logic       sw_run,
    output logic       change1,
    output logic       change2,
    output logic       change3,
    output logic       change4,
    output logic [2:0] view_idx,
    output logic       step_pulse,
    output logic       run_mode
);

    localparam int N_IN     = 3;
    localparam int IDX_MODE = 0;
    localparam int IDX_STEP = 1;
    localparam int IDX_RUN  = 2;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);

    typedef enum logic [2:0] {
        S_ALU  = 3'd0,
        S_MEM  = 3'd1,
        S_FLAG = 3'd2,
        S_PC   = 3'd3,
        S_OFF  = 3'd4
    } state_t;

    // Bit order of the per-input vectors: {sw_run, btn_step, btn_mode}
    logic [N_IN-1:0] w_raw;
    logic [N_IN-1:0] r_s1;
    logic [N_IN-1:0] r_s2;
    logic [N_IN-1:0] r_stable;
    logic [N_IN-1:0] r_stable_d;
    logic [N_IN-1:0] w_stable_next;
    logic [N_IN-1:0] w_rise;

    logic [RUN_W-1:0] r_div;
    logic [RUN_W-1:0] w_div_next;
    logic             r_step_pulse;
    logic             w_step_pulse_next;
    logic             w_run_fall;
    logic             w_div_wrap;

    state_t r_state;
    state_t w_state_next;

    assign w_raw = {sw_run, btn_step, btn_mode};

    // -------------------------------------------------------------------------
    // Per-input debouncer. The counter measures how long the synchronised input
    // has disagreed with the accepted value; any agreement restarts it, so only
    // an uninterrupted run of DEB_CYCLES disagreeing samples is accepted.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
            logic [DEB_W-1:0] r_cnt;
            logic             w_mismatch;
            logic             w_accept;

            assign w_mismatch        = r_s2[gi] ^ r_stable[gi];
            assign w_accept          = w_mismatch && (r_cnt == DEB_LAST);
            assign w_stable_next[gi] = w_accept ? r_s2[gi] : r_stable[gi];
            assign w_rise[gi]        = r_stable[gi] & ~r_stable_d[gi];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_cnt <= '0;
                end else if (w_mismatch && !w_accept) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    endgenerate

    // Synchronisers, accepted values and their one-cycle history
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
        end else begin
            r_s1       <= w_raw;
            r_s2       <= r_s1;
            r_stable   <= w_stable_next;
            r_stable_d <= r_stable;
        end
    end

    assign run_mode = r_stable[IDX_RUN];

    // -------------------------------------------------------------------------
    // Step strobe. In run mode the divider alone drives the strobe. In step
    // mode a debounced btn_step rise drives it, except in the cycle right
    // after run mode drops, so a press coinciding with the switch-over does
    // not leak through as an extra step.
    // -------------------------------------------------------------------------
    assign w_run_fall = ~r_stable[IDX_RUN] & r_stable_d[IDX_RUN];
    assign w_div_wrap = (r_div == RUN_LAST);

    always_comb begin
        w_div_next        = '0;
        w_step_pulse_next = 1'b0;
        if (run_mode) begin
            w_div_next        = w_div_wrap ? '0 : r_div + 1'b1;
            w_step_pulse_next = w_div_wrap;
        end else begin
            w_step_pulse_next = w_rise[IDX_STEP] & ~w_run_fall;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div        <= '0;
            r_step_pulse <= 1'b0;
        end else begin
            r_div        <= w_div_next;
            r_step_pulse <= w_step_pulse_next;
        end
    end

    assign step_pulse = r_step_pulse;

    // -------------------------------------------------------------------------
    // View FSM: one state per debounced btn_mode rise; outputs decoded from
    // the state register so they are glitch-free toward the display mux.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_ALU;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        change1      = 1'b0;
        change2      = 1'b0;
        change3      = 1'b0;
        change4      = 1'b0;
        view_idx     = r_state;
        case (r_state)
            S_ALU: begin
                change1 = 1'b1;
                if (w_rise[IDX_MODE]) w_state_next = S_MEM;
            end
            S_MEM: begin
                change2 = 1'b1;
                if (w_rise[IDX_MODE]) w_state_next = S_FLAG;
            end
            S_FLAG: begin
                change3 = 1'b1;
                if (w_rise[IDX_MODE]) w_state_next = S_PC;
            end
            S_PC: begin
                change4 = 1'b1;
                if (w_rise[IDX_MODE]) w_state_next = S_OFF;
            end
            S_OFF: begin
                if (w_rise[IDX_MODE]) w_state_next = S_ALU;
            end
            // Codes 5..7 cannot be reached normally; recover to the first view
            default: w_state_next = S_ALU;
        endcase
    end

endmodule

// File: tb/tb_debug_panel_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for debug_panel_ctrl (DEB_CYCLES=4, RUN_DIV=8).
// A reference model predicts every output after every clock edge; it reasons
// about "last DEB sampled values", "presses since reset" and "cycles since run
// mode began" rather than counters and state encodings.
// -----------------------------------------------------------------------------
module tb_debug_panel_ctrl;

    localparam int DEB  = 4;
    localparam int RDIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_step = 1'b0;
    logic       sw_run = 1'b0;
    logic       change1, change2, change3, change4;
    logic [2:0] view_idx;
    logic       step_pulse;
    logic       run_mode;

    always #5 clk = ~clk;

    debug_panel_ctrl #(
        .DEB_CYCLES (DEB),
        .DEB_W      (3),
        .RUN_DIV    (RDIV),
        .RUN_W      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_step   (btn_step),
        .sw_run     (sw_run),
        .change1    (change1),
        .change2    (change2),
        .change3    (change3),
        .change4    (change4),
        .view_idx   (view_idx),
        .step_pulse (step_pulse),
        .run_mode   (run_mode)
    );

    int vectors     = 0;
    int miscompares = 0;
    int pulse_count = 0;

    // Reference model state
    int       k = 0;               // index of the next clock edge
    bit [DEB:0] m_win [3];         // raw samples, newest in bit 0
    bit       m_stab [3];          // accepted value after the last edge
    bit       m_stab_prev [3];     // accepted value one edge earlier
    int       m_view = 0;          // number of mode presses since reset, mod 5
    bit       m_pulse = 1'b0;
    int       m_run_start = 0;     // edge at which run mode was last accepted

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, k);
        end
    endtask

    // Predict the outputs produced by the coming edge from the present inputs.
    task automatic model_edge();
        bit raw [3];
        bit nstab [3];
        bit rise_mode;
        bit rise_step;
        raw[0] = btn_mode;
        raw[1] = btn_step;
        raw[2] = sw_run;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_win[i]       = '0;
                m_stab[i]      = 1'b0;
                m_stab_prev[i] = 1'b0;
            end
            m_view  = 0;
            m_pulse = 1'b0;
        end else begin
            rise_mode = m_stab[0] && !m_stab_prev[0];
            rise_step = m_stab[1] && !m_stab_prev[1];
            if (rise_mode) m_view = (m_view + 1) % 5;
            if (m_stab[2])
                m_pulse = ((k - m_run_start) % RDIV) == 0;
            else
                m_pulse = rise_step && !m_stab_prev[2];
            for (int i = 0; i < 3; i++) begin
                // Accept the opposite value once the last DEB synchronised
                // samples (raw samples 2..DEB+1 edges old) all show it.
                nstab[i] = m_stab[i];
                if (m_stab[i] ? (m_win[i][DEB:1] == '0) : (&m_win[i][DEB:1]))
                    nstab[i] = ~m_stab[i];
            end
            if (nstab[2] && !m_stab[2]) m_run_start = k;
            for (int i = 0; i < 3; i++) begin
                m_win[i]       = {m_win[i][DEB-1:0], raw[i]};
                m_stab_prev[i] = m_stab[i];
                m_stab[i]      = nstab[i];
            end
        end
        k++;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            model_edge();
            @(posedge clk);
            #1;
            check("view_idx", 8'(view_idx), 8'(m_view));
            check("changes", {4'b0, change4, change3, change2, change1},
                  {4'b0, m_view == 3, m_view == 2, m_view == 1, m_view == 0});
            check("step_pulse", 8'(step_pulse), 8'(m_pulse));
            check("run_mode", 8'(run_mode), 8'(m_stab[2]));
            if (step_pulse === 1'b1) pulse_count++;
        end
    endtask

    initial begin
        int hold_m;
        int hold_s;
        int hold_r;

        // 1: reset
        rst = 1'b0;
        cyc(3);
        check("rst_change1", 8'(change1), 8'd1);
        check("rst_view", 8'(view_idx), 8'd0);
        check("rst_pulse", 8'(step_pulse), 8'd0);
        rst = 1'b1;
        cyc(2);

        // 2: six mode presses
        repeat (6) begin
            btn_mode = 1'b1; cyc(10);
            btn_mode = 1'b0; cyc(10);
        end
        check("view_after_six", 8'(view_idx), 8'd1);

        // 3: short glitch is rejected
        btn_mode = 1'b1; cyc(3);
        btn_mode = 1'b0; cyc(12);
        check("view_after_glitch", 8'(view_idx), 8'd1);

        // 4: held step button gives one pulse per press
        pulse_count = 0;
        btn_step = 1'b1; cyc(50);
        check("step_hold_count", 8'(pulse_count), 8'd1);
        btn_step = 1'b0; cyc(10);
        btn_step = 1'b1; cyc(20);
        btn_step = 1'b0; cyc(10);
        check("step_second_count", 8'(pulse_count), 8'd2);

        // 5: free-run mode
        pulse_count = 0;
        sw_run = 1'b1;
        cyc(5);
        check("run_not_yet", 8'(run_mode), 8'd0);
        cyc(1);
        check("run_at_edge5", 8'(run_mode), 8'd1);
        repeat (4) begin
            btn_step = 1'b1; cyc(6);
            btn_step = 1'b0; cyc(6);
        end
        check("run_pulse_count", 8'(pulse_count), 8'd6);
        sw_run = 1'b0;
        cyc(20);

        // 6: reset in the middle of free-run with view 3
        repeat (2) begin
            btn_mode = 1'b1; cyc(10);
            btn_mode = 1'b0; cyc(10);
        end
        check("view_before_rst", 8'(view_idx), 8'd3);
        sw_run = 1'b1;
        cyc(30);
        rst = 1'b0;
        cyc(1);
        check("midrun_rst_view", 8'(view_idx), 8'd0);
        check("midrun_rst_run", 8'(run_mode), 8'd0);
        rst = 1'b1;
        pulse_count = 0;
        cyc(13);
        check("resume_quiet", 8'(pulse_count), 8'd0);
        cyc(1);
        check("resume_pulse", 8'(step_pulse), 8'd1);

        // 7: randomized inputs with random hold times and rare resets
        hold_m = 0; hold_s = 0; hold_r = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold_m == 0) begin btn_mode = 1'($urandom_range(0, 1)); hold_m = $urandom_range(1, 12); end
            if (hold_s == 0) begin btn_step = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 12); end
            if (hold_r == 0) begin sw_run   = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 60); end
            hold_m--; hold_s--; hold_r--;
            rst = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        rst = 1'b1;
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
